// File: rtl/odd_parity_frame_rx.sv
// odd_parity_frame_rx
//   Deserializes a bit-strobed serial frame: start(0), DATA_W data bits
//   (LSB first), one parity bit, one stop bit. The captured word and the
//   parity bit are offered downstream through a valid/ready holding
//   register. Parity is passed through unmodified; it is never evaluated here.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      synchronous active-low reset
//   bit_en     bit strobe; sdata is sampled only when bit_en=1
//   sdata      serial line, idle level 1
//   data_out   captured data word (bit 0 = first data bit received)
//   parity_out captured parity bit
//   out_valid  holding register contains an unconsumed frame
//   out_ready  consumer accepts the frame when out_valid && out_ready
//   busy       receiver is inside a frame (not IDLE)
//   frame_err  one-cycle pulse: stop bit sampled as 0
//   overrun    one-cycle pulse: completed frame dropped, holding register full
module odd_parity_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              sdata,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [DATA_W-1:0] data_q;
  logic              parity_q;
  logic              valid_q;
  logic              busy_q;
  logic              ferr_q;
  logic              ovr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;

      // Consumption first; a commit on the same edge overrides it below.
      if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      if (bit_en) begin
        case (state_q)
          S_IDLE: begin
            if (!sdata) begin
              state_q <= S_DATA;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_DATA: begin
            shift_q[cnt_q] <= sdata;
            if (cnt_q == CW'(DATA_W - 1)) begin
              state_q <= S_PARITY;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_PARITY: begin
            par_q   <= sdata;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (sdata) begin
              // Holding register is free if empty or being drained this edge.
              if (!valid_q || out_ready) begin
                data_q   <= shift_q;
                parity_q <= par_q;
                valid_q  <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign parity_out = parity_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_odd_parity_frame_rx.sv
module tb_odd_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       sdata = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] data_out;
  logic       parity_out;
  logic       out_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;

  odd_parity_frame_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .sdata      (sdata),
    .data_out   (data_out),
    .parity_out (parity_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap idle cycles with bit_en=0 and a random line level, then one strobe.
  task automatic send_bit(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      sdata = 1'($urandom_range(0, 1));
      tick();
    end
    sdata  = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    sdata  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int gap, input logic rdy_at_stop);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    if (rdy_at_stop) out_ready = 1'b1;
    send_bit(s, gap);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_parity", 32'(parity_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-frame, then a clean 0x3C frame
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(data_out), 32'h00);
    send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b0);
    chk("f3c_valid", 32'(out_valid), 32'd1);
    chk("f3c_data", 32'(data_out), 32'h3C);
    chk("f3c_par", 32'(parity_out), 32'd1);
    consume();
    chk("f3c_drained", 32'(out_valid), 32'd0);
    chk("f3c_hold", 32'(data_out), 32'h3C);

    // Single frame 0xA5, bit_en every 4th cycle, line noise between strobes
    send_frame(8'hA5, 1'b1, 1'b0 ^ 1'b1, 3, 1'b0);
    chk("fa5_valid", 32'(out_valid), 32'd1);
    chk("fa5_data", 32'(data_out), 32'hA5);
    chk("fa5_par", 32'(parity_out), 32'd1);
    chk("fa5_ferr", 32'(frame_err), 32'd0);
    repeat (5) tick();
    chk("fa5_stable_valid", 32'(out_valid), 32'd1);
    chk("fa5_stable_data", 32'(data_out), 32'hA5);
    consume();

    // Parity pass-through: wrong odd parity is not flagged here
    send_frame(8'h07, 1'b1, 1'b1, 1, 1'b0);
    chk("f07_valid", 32'(out_valid), 32'd1);
    chk("f07_data", 32'(data_out), 32'h07);
    chk("f07_par", 32'(parity_out), 32'd1);
    chk("f07_ferr", 32'(frame_err), 32'd0);
    consume();

    // Framing error on 0x55, then 0x01 accepted
    send_frame(8'h55, 1'b1, 1'b0, 0, 1'b0);
    chk("f55_ferr", 32'(frame_err), 32'd1);
    chk("f55_valid", 32'(out_valid), 32'd0);
    chk("f55_ovr", 32'(overrun), 32'd0);
    chk("f55_busy", 32'(busy), 32'd0);
    tick();
    chk("f55_ferr_width", 32'(frame_err), 32'd0);
    send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0);
    chk("f01_valid", 32'(out_valid), 32'd1);
    chk("f01_data", 32'(data_out), 32'h01);
    chk("f01_par", 32'(parity_out), 32'd0);
    consume();

    // Back-to-back, consumer stalled: overrun keeps 0x11
    send_frame(8'h11, 1'b1, 1'b1, 0, 1'b0);
    chk("f11_valid", 32'(out_valid), 32'd1);
    send_frame(8'h22, 1'b1, 1'b1, 0, 1'b0);
    chk("f22_ovr", 32'(overrun), 32'd1);
    chk("f22_ovr_data", 32'(data_out), 32'h11);
    chk("f22_ovr_valid", 32'(out_valid), 32'd1);
    chk("f22_ovr_ferr", 32'(frame_err), 32'd0);
    tick();
    chk("f22_ovr_width", 32'(overrun), 32'd0);
    // Same frame, consumer ready on the completion edge: replace in place
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1);
    out_ready = 1'b0;
    chk("f22_rdy_data", 32'(data_out), 32'h22);
    chk("f22_rdy_par", 32'(parity_out), 32'd0);
    chk("f22_rdy_valid", 32'(out_valid), 32'd1);
    chk("f22_rdy_ovr", 32'(overrun), 32'd0);
    consume();
    chk("f22_drained", 32'(out_valid), 32'd0);

    // Idle noise: 20 strobes of sdata=1 keep the receiver idle
    begin
      int busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
        send_bit(1'b1, 0);
        if (busy) busy_seen++;
      end
      chk("idle_busy_count", 32'(busy_seen), 32'd0);
    end
    // Line toggling without bit_en changes nothing
    for (int i = 0; i < 10; i++) begin
      sdata = 1'(i % 2);
      tick();
    end
    sdata = 1'b1;
    chk("gate_busy", 32'(busy), 32'd0);
    chk("gate_valid", 32'(out_valid), 32'd0);
    chk("gate_data", 32'(data_out), 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
